// File: rtl/bt_uart_rx_pkg.sv
// Shared definitions for the Bluetooth-link UART receiver: FSM states,
// register map, STATUS bit positions and the oversample divider helper.
package bt_uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_FRAME_ERR = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int OS_RATE = 16;
    // The counter value seen on the 8th tick of a bit, i.e. mid-bit.
    localparam logic [3:0] SAMPLE_TICK = 4'd7;

    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + (OS_RATE * baud) / 2) / (OS_RATE * baud);
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO for received bytes. A push into a full FIFO is dropped
// and flagged, unless a pop in the same cycle makes room for it.
module rx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign dout_o     = mem_q[rd_ptr_q];
    assign do_pop     = pop_i & ~empty_o;
    assign do_push    = push_i & (~full_o | do_pop);
    assign overflow_o = push_i & full_o & ~do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1 UART receiver for the Bluetooth module TX line, with a byte FIFO and
// an Avalon-MM register port (DATA / STATUS / CONTROL) for the Nios II.
module bt_uart_rx
    import bt_uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rxd,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);
    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic             tick, sample, start_edge;

    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             push, frame_err_set;

    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             rx_ie_q, rx_ie_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [31:0]      status_w, rd_word;
    logic             pop, status_wr;

    logic [7:0]       fifo_head;
    logic             fifo_full, fifo_empty, fifo_ovf;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_wdata;

    assign unused_wdata = ^{writedata[31:4], writedata[1]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // Oversample timebase; both counters re-phase on the start edge so the
    // 8th tick lands mid-bit.
    assign start_edge = (state_q == IDLE) & rxd_prev_q & ~rxd_sync_q;
    assign tick       = (div_cnt_q == DIV_W'(DIV - 1));
    assign sample     = tick & (tick_cnt_q == SAMPLE_TICK);

    always_comb begin
        div_cnt_d  = div_cnt_q + DIV_W'(1);
        tick_cnt_d = tick_cnt_q;
        if (start_edge) begin
            div_cnt_d  = '0;
            tick_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d  = '0;
            tick_cnt_d = tick_cnt_q + 4'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        push          = 1'b0;
        frame_err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) state_d = START;
            end
            START: begin
                if (sample) begin
                    if (!rxd_sync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shreg_d   = {rxd_sync_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    if (rxd_sync_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_d       = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_sync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    rx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_n_i    (reset_n),
        .push_i     (push),
        .din_i      (shreg_q),
        .pop_i      (pop),
        .dout_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .overflow_o (fifo_ovf)
    );

    assign pop       = read & (address == ADDR_DATA) & ~fifo_empty;
    assign status_wr = write & (address == ADDR_STATUS);

    // A set in the same cycle as a clear wins.
    assign frame_err_d = frame_err_set | (frame_err_q & ~(status_wr & writedata[ST_FRAME_ERR]));
    assign overrun_d   = fifo_ovf | (overrun_q & ~(status_wr & writedata[ST_OVERRUN]));
    assign rx_ie_d     = (write && address == ADDR_CONTROL) ? writedata[0] : rx_ie_q;

    always_comb begin
        status_w                           = '0;
        status_w[ST_NOT_EMPTY]             = ~fifo_empty;
        status_w[ST_FULL]                  = fifo_full;
        status_w[ST_FRAME_ERR]             = frame_err_q;
        status_w[ST_OVERRUN]               = overrun_q;
        status_w[ST_COUNT_LSB +: CNT_W]    = fifo_count;
        case (address)
            ADDR_DATA:    rd_word = fifo_empty ? 32'd0 : {24'd0, fifo_head};
            ADDR_STATUS:  rd_word = status_w;
            ADDR_CONTROL: rd_word = {31'd0, rx_ie_q};
            default:      rd_word = 32'd0;
        endcase
        readdata_d = read ? rd_word : readdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_ie_q     <= 1'b0;
            readdata_q  <= '0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_ie_q     <= rx_ie_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = rx_ie_q & (~fifo_empty | frame_err_q | overrun_q);

endmodule

// File: tb/tb_bt_uart_rx.sv
// Directed plus randomized bench for bt_uart_rx against a queue-based model
// of the receiver's observable register behaviour.
module tb_bt_uart_rx;
    localparam int CLK_HZ     = 9216000;
    localparam int BAUD       = 115200;
    localparam int FIFO_DEPTH = 16;
    localparam int BIT        = CLK_HZ / BAUD;
    localparam int TICK       = BIT / 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rxd;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_q[$];
    bit         m_ferr, m_ovr, m_ie;

    always #5 clk = ~clk;

    bt_uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rxd       (rxd),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: what software should see through STATUS, DATA and irq.
    function automatic logic [31:0] m_status();
        logic [31:0] s;
        int n;
        n       = m_q.size();
        s       = 32'd0;
        s[0]    = (n != 0);
        s[1]    = (n == FIFO_DEPTH);
        s[2]    = m_ferr;
        s[3]    = m_ovr;
        s[15:8] = 8'(n);
        return s;
    endfunction

    function automatic logic m_irq();
        return m_ie & ((m_q.size() != 0) | m_ferr | m_ovr);
    endfunction

    function automatic logic [31:0] m_pop();
        if (m_q.size() == 0) return 32'd0;
        return {24'd0, m_q.pop_front()};
    endfunction

    task automatic m_rx(input logic [7:0] b, input bit good);
        if (!good) m_ferr = 1'b1;
        else if (m_q.size() == FIFO_DEPTH) m_ovr = 1'b1;
        else m_q.push_back(b);
    endtask

    task automatic m_reset();
        m_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        m_ie   = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d    = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        address   = a;
        writedata = v;
        write     = 1'b1;
        @(negedge clk);
        write = 1'b0;
        if (a == 2'd1) begin
            if (v[2]) m_ferr = 1'b0;
            if (v[3]) m_ovr  = 1'b0;
        end else if (a == 2'd2) begin
            m_ie = v[0];
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int extra_low);
        @(negedge clk);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stop;
        repeat (BIT) @(negedge clk);
        if (!stop) repeat (extra_low * BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT / 4) @(negedge clk);
        m_rx(b, stop);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        bit          good;

        reset_n   = 1'b0;
        rxd       = 1'b1;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'd0;
        m_reset();
        repeat (4) @(negedge clk);
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        bus_read(2'd1, d);  check("reset_status", d, 32'd0);
        bus_read(2'd2, d);  check("reset_control", d, 32'd0);
        bus_read(2'd0, d);  check("empty_data_read", d, 32'd0);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, d);  check("addr3_read", d, 32'd0);
        bus_read(2'd2, d);  check("addr3_write_ignored", d, 32'd0);

        // Basic receive
        send_frame(8'h55, 1'b1, 0);
        bus_read(2'd1, d);  check("basic_status", d, 32'h0000_0101);
        bus_read(2'd0, d);  check("basic_data", d, 32'h55);
        void'(m_pop());
        bus_read(2'd1, d);  check("basic_status_after", d, 32'd0);

        // Start-bit glitch
        @(negedge clk);
        rxd = 1'b0;
        repeat (5 * TICK) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        bus_read(2'd1, d);  check("glitch_status", d, m_status());

        // Framing error, line held low, then a clean byte
        send_frame(8'hA3, 1'b0, 2);
        bus_read(2'd1, d);  check("ferr_status", d, 32'h0000_0004);
        send_frame(8'h12, 1'b1, 0);
        bus_read(2'd1, d);  check("ferr_then_byte_status", d, m_status());
        bus_read(2'd0, d);  check("ferr_then_byte_data", d, m_pop());
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, d);  check("ferr_cleared", d, 32'd0);

        // Overrun
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 0);
        bus_read(2'd1, d);  check("ovr_status", d, 32'h0000_100B);
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, d);
            check("ovr_data", d, m_pop());
        end
        bus_read(2'd1, d);  check("ovr_drained_status", d, 32'h0000_0008);
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, d);  check("ovr_cleared", d, m_status());

        // Interrupt
        send_frame(8'h7E, 1'b1, 0);
        check("irq_disabled", {31'd0, irq}, 32'd0);
        bus_write(2'd2, 32'h1);
        check("irq_enabled", {31'd0, irq}, 32'd1);
        bus_read(2'd0, d);  check("irq_data", d, m_pop());
        check("irq_after_read", {31'd0, irq}, 32'd0);

        // Reset in the middle of a byte
        b = 8'($urandom);
        send_frame(b, 1'b1, 0);
        check("pre_reset_irq", {31'd0, irq}, {31'd0, m_irq()});
        @(negedge clk);
        rxd = 1'b0;
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_readdata", readdata, 32'd0);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        rxd = 1'b1;
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(2'd1, d);  check("postreset_status", d, 32'd0);
        bus_read(2'd2, d);  check("postreset_control", d, 32'd0);
        send_frame(8'hC3, 1'b1, 0);
        bus_read(2'd1, d);  check("postreset_rx_status", d, 32'h0000_0101);
        bus_read(2'd0, d);  check("postreset_rx_data", d, 32'hC3);
        void'(m_pop());

        // Randomized traffic against the model
        bus_write(2'd2, {31'd0, 1'($urandom)});
        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    b    = 8'($urandom);
                    good = ($urandom_range(0, 7) != 0);
                    send_frame(b, good, $urandom_range(0, 1));
                end
                2: begin
                    bus_read(2'd0, d);
                    check("rand_data", d, m_pop());
                end
                default: begin
                    bus_read(2'd1, d);
                    check("rand_status", d, m_status());
                    bus_write(2'd1, {28'd0, 2'($urandom), 2'd0});
                end
            endcase
            check("rand_irq", {31'd0, irq}, {31'd0, m_irq()});
        end
        bus_read(2'd1, d);  check("rand_final_status", d, m_status());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
